// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and constants for the writeback register file
package mips_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if: writeback, decode-read and status signals of the register file
interface wb_reg_file_if #(
    parameter int DATA_W = mips_pkg::DEF_DATA_W
);
    import mips_pkg::*;
    logic                  reg_wr_i;
    logic                  mem_to_reg_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic [DATA_W-1:0]     res_alu_i;
    logic [DATA_W-1:0]     read_data_i;
    logic [REG_ADDR_W-1:0] rs_addr_i;
    logic [REG_ADDR_W-1:0] rt_addr_i;
    logic [DATA_W-1:0]     rs_data_o;
    logic [DATA_W-1:0]     rt_data_o;
    logic [DATA_W-1:0]     wb_data_o;
    logic [CNT_W-1:0]      wr_cnt_o;
    modport slave (
        input  reg_wr_i, mem_to_reg_i, rd_i, res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
        output rs_data_o, rt_data_o, wb_data_o, wr_cnt_o
    );
    modport master (
        output reg_wr_i, mem_to_reg_i, rd_i, res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
        input  rs_data_o, rt_data_o, wb_data_o, wr_cnt_o
    );
endinterface

// File: rtl/wb_rd_port.sv
// wb_rd_port: combinational read port with r0 masking; WB_BYPASS_EN adds write-through
module wb_rd_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 32
) (
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     regs_i [NUM_REGS],
`ifdef WB_BYPASS_EN
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]     wb_data_i,
`endif
    output logic [DATA_W-1:0]     data_o
);
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] sel;

    // select stored value, optionally override with in-flight write, then force zero for r0 and reset
    always_comb begin
        stored = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_i == REG_ADDR_W'(i)) stored = regs_i[i];
`ifdef WB_BYPASS_EN
        sel = (wr_en_i && addr_i == rd_i) ? wb_data_i : stored;
`else
        sel = stored;
`endif
        data_o = (!reset_n || addr_i == ZERO_REG) ? '0 : sel;
    end
endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: MIPS writeback register file with commit counter; define WB_BYPASS_EN for write-through reads
module wb_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 32
) (
    input logic         clk,
    input logic         reset_n,
    wb_reg_file_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d;
    logic [DATA_W-1:0] wb_data;
    logic              commit;

    // writeback mux, commit qualification and next register/counter values
    always_comb begin
        wb_data  = bus.mem_to_reg_i ? bus.read_data_i : bus.res_alu_i;
        commit   = bus.reg_wr_i && bus.rd_i != ZERO_REG;
        wr_cnt_d = wr_cnt_q + CNT_W'(commit);
        for (int i = 0; i < NUM_REGS; i++)
            regs_d[i] = (commit && bus.rd_i == REG_ADDR_W'(i)) ? wb_data : regs_q[i];
    end

    // storage and counter, cleared immediately when reset_n drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            regs_q   <= regs_d;
        end
    end

    assign bus.wb_data_o = wb_data;
    assign bus.wr_cnt_o  = wr_cnt_q;

    wb_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rs_port (
        .reset_n   (reset_n),
        .addr_i    (bus.rs_addr_i),
        .regs_i    (regs_q),
`ifdef WB_BYPASS_EN
        .wr_en_i   (commit),
        .rd_i      (bus.rd_i),
        .wb_data_i (wb_data),
`endif
        .data_o    (bus.rs_data_o)
    );

    wb_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rt_port (
        .reset_n   (reset_n),
        .addr_i    (bus.rt_addr_i),
        .regs_i    (regs_q),
`ifdef WB_BYPASS_EN
        .wr_en_i   (commit),
        .rd_i      (bus.rd_i),
        .wb_data_i (wb_data),
`endif
        .data_o    (bus.rt_data_o)
    );
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed and randomized checks of wb_reg_file against an array model
module tb_wb_reg_file;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mem [32];
    logic [31:0] cnt = '0;

    wb_reg_file_if #(.DATA_W(32)) bus ();

    wb_reg_file #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic wr,
                                           input logic [4:0] rd, input logic [31:0] wv);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wr && rd == a) return wv;
`else
        if (wr && rd == a && wv == 32'd0) return mem[a];
`endif
        return mem[a];
    endfunction

    task automatic drive(input logic wr, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.reg_wr_i     = wr;
        bus.mem_to_reg_i = m2r;
        bus.rd_i         = rd;
        bus.res_alu_i    = alu;
        bus.read_data_i  = ld;
        bus.rs_addr_i    = rs;
        bus.rt_addr_i    = rt;
    endtask

    task automatic cycle(input logic wr, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] wv;
        wv = m2r ? ld : alu;
        drive(wr, m2r, rd, alu, ld, rs, rt);
        #1;
        check("wb_data", bus.wb_data_o, wv);
        check("rs_data", bus.rs_data_o, exp_rd(rs, wr, rd, wv));
        check("rt_data", bus.rt_data_o, exp_rd(rt, wr, rd, wv));
        check("wr_cnt", bus.wr_cnt_o, cnt);
        @(posedge clk);
        if (wr && rd != 5'd0) begin
            mem[rd] = wv;
            cnt = cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.reg_wr_i  = 1'b0;
        bus.rs_addr_i = a;
        #1;
        check(tag, bus.rs_data_o, exp);
    endtask

    initial begin
        logic [4:0] rd;
        foreach (mem[i]) mem[i] = '0;
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd4, 32'hCAFE, '0, 5'd4, 5'd4);
        #1;
        check("rst_rs", bus.rs_data_o, 32'd0);
        check("rst_rt", bus.rt_data_o, 32'd0);
        check("rst_cnt", bus.wr_cnt_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        cycle(1'b1, 1'b0, 5'd5, 32'h1234, 32'h5555, 5'd0, 5'd0);
        peek("alu_write_r5", 5'd5, 32'h1234);
        check("alu_write_cnt", bus.wr_cnt_o, 32'd1);

        cycle(1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h0, 5'd0, 5'd0);
        peek("r0_read", 5'd0, 32'd0);
        check("r0_write_cnt", bus.wr_cnt_o, 32'd1);

        drive(1'b1, 1'b1, 5'd7, 32'h1, 32'hDEAD_BEEF, 5'd0, 5'd0);
        #1;
        check("load_wb", bus.wb_data_o, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 5'd7, 32'h1, 32'hDEAD_BEEF, 5'd0, 5'd0);
        peek("load_r7", 5'd7, 32'hDEAD_BEEF);

        cycle(1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd3, 32'hA5, 32'h0, 5'd3, 5'd3);
        #1;
`ifdef WB_BYPASS_EN
        check("same_cycle_r3", bus.rs_data_o, 32'hA5);
`else
        check("same_cycle_r3", bus.rs_data_o, 32'h11);
`endif
        cycle(1'b1, 1'b0, 5'd3, 32'hA5, 32'h0, 5'd3, 5'd3);
        peek("next_cycle_r3", 5'd3, 32'hA5);

        for (int n = 0; n < 300; n++) begin
            rd = 5'($urandom);
            cycle(($urandom % 4) != 0, 1'($urandom), rd, $urandom, $urandom,
                  ($urandom % 3 == 0) ? rd : 5'($urandom),
                  ($urandom % 4 == 0) ? rd : 5'($urandom));
        end

        bus.reg_wr_i = 1'b0;
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        cnt = 32'hFFFF_FFFF;
        cycle(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 5'd9, 5'd0);
        check("cnt_wrap", bus.wr_cnt_o, 32'd0);

        for (int i = 1; i < 32; i++)
            cycle(1'b1, 1'($urandom), 5'(i), $urandom | 32'h1, $urandom | 32'h1, 5'(i - 1), 5'(i));
        drive(1'b1, 1'b0, 5'd4, 32'h4444, 32'h0, 5'd0, 5'd0);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.rs_addr_i = 5'(i);
            bus.rt_addr_i = 5'(i + 16);
            #1;
            check("async_rst_rs", bus.rs_data_o, 32'd0);
            check("async_rst_rt", bus.rt_data_o, 32'd0);
            check("async_rst_cnt", bus.wr_cnt_o, 32'd0);
        end
        foreach (mem[i]) mem[i] = '0;
        cnt = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        peek("post_rst_r4", 5'd4, 32'd0);
        check("post_rst_cnt", bus.wr_cnt_o, 32'd0);

        for (int n = 0; n < 100; n++) begin
            rd = 5'($urandom);
            cycle(($urandom % 3) != 0, 1'($urandom), rd, $urandom, $urandom,
                  ($urandom % 2 == 0) ? rd : 5'($urandom), 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_reg_file.md
WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register and datapath width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning the number of architectural registers; the address width is log2(NUM_REGS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port reg_wr_i, input, 1, meaning the writeback write enable from the MEM/WB register.
REQ-006 SHALL have port mem_to_reg_i, input, 1, meaning write-data select: 1 = load data, 0 = ALU result.
REQ-007 SHALL have port rd_i, input, 5, meaning the writeback destination register.
REQ-008 SHALL have port res_alu_i, input, DATA_W, meaning the ALU result.
REQ-009 SHALL have port read_data_i, input, DATA_W, meaning the load data.
REQ-010 SHALL have ports rs_addr_i and rt_addr_i, input, 5 each, meaning the decode-stage read addresses.
REQ-011 SHALL have ports rs_data_o and rt_data_o, output, DATA_W each, meaning the read data.
REQ-012 SHALL have port wb_data_o, output, DATA_W, meaning the selected writeback value, exposed for forwarding.
REQ-013 SHALL have port wr_cnt_o, output, 32, meaning the count of committed register writes.

Function
REQ-014 SHALL drive wb_data_o combinationally as read_data_i when mem_to_reg_i=1, else res_alu_i, regardless of reg_wr_i.
REQ-015 SHALL treat a write as committed when reg_wr_i=1 and rd_i!=0 at a rising clk edge; the write stores wb_data_o into register rd_i, with the new value visible in storage one cycle later.
REQ-016 SHALL never write register 0; rs_data_o/rt_data_o SHALL be 0 whenever the respective address is 0, including under bypass.
REQ-017 SHALL provide combinational (zero-latency) read ports that are independent of each other; rs_addr_i==rt_addr_i returns identical data.
REQ-018 SHALL increment wr_cnt_o by 1 on each committed write, with no increment when reg_wr_i=0 or rd_i=0.
REQ-019 SHALL wrap wr_cnt_o from 0xFFFF_FFFF to 0x0000_0000 without any flag.
REQ-020 SHALL, for simultaneous write and read of the same nonzero register, return data per REQ-025/026.

Reset
REQ-021 SHALL, on reset_n low, immediately and asynchronously clear all registers to 0 and clear wr_cnt_o to 0, independent of clk.
REQ-022 SHALL drive rs_data_o=0, rt_data_o=0 and wr_cnt_o=0 while reset_n is low; wb_data_o SHALL remain purely combinational.
REQ-023 SHALL discard any write coinciding with reset assertion; the first commit is possible at the first rising clk edge with reset_n high.
REQ-024 SHALL treat reset deassertion as synchronous to clk, with the external synchronizer outside this block.

Configuration
REQ-025 SHALL, with WB_BYPASS_EN defined: when reg_wr_i=1, rd_i!=0 and a read address equals rd_i, return wb_data_o on that read port in the same cycle (write-through).
REQ-026 SHALL, with WB_BYPASS_EN undefined: have read ports return stored contents only, so the written value appears the cycle after the commit.

Structure
REQ-027 SHALL place DATA_W default, REG_ADDR_W=5, ZERO_REG=5'd0 and the wr_cnt width constant in shared package mips_pkg.
REQ-028 SHALL implement each read port, including address-zero masking and the optional bypass, as sub-module wb_rd_port, instantiated twice.

Verification
REQ-029 SHALL verify: reg_wr_i=1, rd_i=5, mem_to_reg_i=0, res_alu_i=0x1234 -> next cycle rs_addr_i=5 reads 0x1234 and wr_cnt_o=1.
REQ-030 SHALL verify: reg_wr_i=1, rd_i=0, res_alu_i=0xFFFF -> rs_addr_i=0 reads 0 and wr_cnt_o is unchanged.
REQ-031 SHALL verify: mem_to_reg_i=1, read_data_i=0xDEAD_BEEF, res_alu_i=0x1, rd_i=7 -> wb_data_o=0xDEAD_BEEF and r7=0xDEAD_BEEF.
REQ-032 SHALL verify: same-cycle write of r3=0xA5 with rs_addr_i=3, where r3 was previously 0x11 -> rs_data_o=0xA5 with WB_BYPASS_EN, and 0x11 then 0xA5 without.
REQ-033 SHALL verify: force wr_cnt to 0xFFFF_FFFF and commit one write -> wr_cnt_o=0.
REQ-034 SHALL verify: reset_n pulsed low mid-cycle after writes to r1..r31 -> all reads and wr_cnt_o are 0 before the next clk edge.
